// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the fetch and M-stage requesters.
// Data wins by default; a starvation counter can force a fetch grant, and a timeout aborts silent grants.
module mem_port_arbiter #(
    parameter int TIMEOUT    = 255,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ready,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [3:0]  d_be,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ready,
    output logic        m_req,
    output logic        m_we,
    output logic [3:0]  m_be,
    output logic [31:0] m_addr,
    output logic [31:0] m_wdata,
    input  logic        m_ack,
    input  logic [31:0] m_rdata,
    output logic        stall,
    output logic        err,
    output logic [1:0]  dbgState
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DGRANT = 2'd1,
        IGRANT = 2'd2,
        NULLD  = 2'd3
    } stateT;

    stateT         state;
    logic [TW-1:0] timeoutCnt;
    logic [SW-1:0] starveCnt;
    logic          dEligible;
    logic          iEligible;
    logic          starveHit;
    logic          takeFetch;
    logic          takeData;
    logic          takeNull;
    logic          lastCycle;

    // Handshake: a requester holds req high until its ready pulses for one cycle;
    // in that ready cycle the still-high req is the finished request, so it is not eligible.
    assign dEligible = d_req & ~d_ready;
    assign iEligible = i_req & ~i_ready;
    assign starveHit = iEligible && (starveCnt == SW'(STARVE_MAX));
    assign takeFetch = iEligible && (starveHit || !dEligible);
    assign takeData  = dEligible && !starveHit && (d_be != 4'd0);
    assign takeNull  = dEligible && !starveHit && (d_be == 4'd0);
    assign lastCycle = (timeoutCnt == TW'(TIMEOUT - 1));

    assign stall    = (d_req & ~d_ready) | (i_req & ~i_ready);
    assign dbgState = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            timeoutCnt <= '0;
            starveCnt  <= '0;
            m_req      <= 1'b0;
            m_we       <= 1'b0;
            m_be       <= 4'd0;
            m_addr     <= '0;
            m_wdata    <= '0;
            d_rdata    <= '0;
            d_ready    <= 1'b0;
            i_rdata    <= '0;
            i_ready    <= 1'b0;
            err        <= 1'b0;
        end else begin
            d_ready <= 1'b0;
            i_ready <= 1'b0;
            err     <= 1'b0;

            // Counts data grants taken while a fetch is waiting.
            if (!i_req || (state == IDLE && takeFetch)) begin
                starveCnt <= '0;
            end else if (state == IDLE && takeData && starveCnt != SW'(STARVE_MAX)) begin
                starveCnt <= starveCnt + SW'(1);
            end

            case (state)
                IDLE: begin
                    if (takeFetch) begin
                        state      <= IGRANT;
                        m_req      <= 1'b1;
                        m_we       <= 1'b0;
                        m_be       <= 4'hF;
                        m_addr     <= i_addr;
                        m_wdata    <= '0;
                        timeoutCnt <= '0;
                    end else if (takeData) begin
                        state      <= DGRANT;
                        m_req      <= 1'b1;
                        m_we       <= d_we;
                        m_be       <= d_be;
                        m_addr     <= d_addr;
                        m_wdata    <= d_wdata;
                        timeoutCnt <= '0;
                    end else if (takeNull) begin
                        state <= NULLD;
                    end
                end
                DGRANT, IGRANT: begin
                    if (m_ack) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                        if (state == DGRANT) begin
                            d_ready <= 1'b1;
                            d_rdata <= m_we ? 32'd0 : m_rdata;
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= m_rdata;
                        end
                    end else if (lastCycle) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                        err   <= 1'b1;
                        if (state == DGRANT) begin
                            d_ready <= 1'b1;
                            d_rdata <= '0;
                        end else begin
                            i_ready <= 1'b1;
                            i_rdata <= '0;
                        end
                    end else begin
                        timeoutCnt <= timeoutCnt + TW'(1);
                    end
                end
                NULLD: begin
                    state   <= IDLE;
                    d_ready <= 1'b1;
                    d_rdata <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset values, a table of single transactions, two
// hand-written multi-cycle sequences, then random traffic against a reference model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT    = 255;
    localparam int STARVE_MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ready;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ready;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        stall;
    logic        err;
    logic [1:0]  dbgState;

    always #5 clk = ~clk;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata),
        .stall(stall), .err(err), .dbgState(dbgState)
    );

    int vecCnt  = 0;
    int missCnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecCnt++;
        if (act !== exp) begin
            missCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One isolated transaction and what it must produce.
    typedef struct {
        logic        fetch;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          lat;       // grant cycle in which memory acks; 0 = never
        logic [31:0] rdata;
        int          expCyc;    // cycles with m_req high
        int          expReady;  // edges from request to ready pulse
        logic [31:0] expRdata;
        int          expErr;
        logic [3:0]  expMBe;
        logic        expMWe;
        logic [31:0] expMWdata;
    } row_t;

    function automatic row_t mkRow(input logic fetch, input logic we, input logic [3:0] be,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input int lat, input logic [31:0] rdata, input int expCyc,
                                   input int expReady, input logic [31:0] expRdata, input int expErr);
        row_t r;
        r.fetch = fetch; r.we = we; r.be = be; r.addr = addr; r.wdata = wdata;
        r.lat = lat; r.rdata = rdata; r.expCyc = expCyc; r.expReady = expReady;
        r.expRdata = expRdata; r.expErr = expErr;
        r.expMBe    = fetch ? 4'hF : be;
        r.expMWe    = fetch ? 1'b0 : we;
        r.expMWdata = fetch ? 32'd0 : wdata;
        return r;
    endfunction

    task automatic clearInputs();
        i_req = 0; i_addr = '0; d_req = 0; d_we = 0; d_be = '0; d_addr = '0; d_wdata = '0;
        m_ack = 0; m_rdata = '0;
    endtask

    task automatic doReset();
        reset = 1'b0;
        clearInputs();
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic runRow(input row_t v, input string tag);
        int edges, grantCyc, readyAt, errCnt;
        logic stable, wrongReady, done;
        logic [31:0] got;
        edges = 0; grantCyc = 0; readyAt = 0; errCnt = 0;
        stable = 1; wrongReady = 0; done = 0; got = '0;
        if (v.fetch) begin
            i_req = 1; i_addr = v.addr;
        end else begin
            d_req = 1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
        end
        while (!done && edges < 400) begin
            @(posedge clk); #1;
            edges++;
            if (m_req) begin
                grantCyc++;
                if ({m_we, m_be, m_addr, m_wdata} !== {v.expMWe, v.expMBe, v.addr, v.expMWdata})
                    stable = 0;
            end
            if (err) errCnt++;
            if (d_ready || i_ready) begin
                done = 1;
                readyAt = edges;
                got = v.fetch ? i_rdata : d_rdata;
                wrongReady = v.fetch ? d_ready : i_ready;
                d_req = 0; i_req = 0;
            end
            m_ack = m_req && (grantCyc == v.lat);
            m_rdata = v.rdata;
        end
        d_req = 0; i_req = 0; m_ack = 0;
        @(posedge clk); #1;
        chk({tag, " m_req_cycles"}, 64'(grantCyc), 64'(v.expCyc));
        chk({tag, " ready_at"}, 64'(readyAt), 64'(v.expReady));
        chk({tag, " rdata"}, 64'(got), 64'(v.expRdata));
        chk({tag, " err_count"}, 64'(errCnt), 64'(v.expErr));
        chk({tag, " bus_stable"}, 64'(stable), 64'd1);
        chk({tag, " other_ready"}, 64'(wrongReady), 64'd0);
        chk({tag, " after_idle"}, 64'({d_ready, i_ready, err, m_req, dbgState}), 64'd0);
    endtask

    // Reference model: tracks which transaction owns the bus and what it owes.
    int          ph;          // 0 nothing, 1 data on bus, 2 fetch on bus, 3 empty data access
    int          elapsed;
    int          dataRun;
    logic        tWe;
    logic [3:0]  tBe;
    logic [31:0] tAddr, tWdata;
    logic        eD, eI, eE;
    logic [31:0] eDR, eIR;
    logic        pDReq, pDWe, pIReq, pAck;
    logic [3:0]  pDBe;
    logic [31:0] pDAddr, pDWdata, pIAddr, pRdata;
    logic        dPend, iPend;

    task automatic modelEdge();
        logic nd, ni, ne, dw, iw, goI;
        nd = 0; ni = 0; ne = 0;
        if (ph == 0) begin
            dw = pDReq && !eD;
            iw = pIReq && !eI;
            goI = iw && (!dw || dataRun >= STARVE_MAX);
            if (!pIReq || goI) dataRun = 0;
            else if (dw && pDBe != 0 && dataRun < STARVE_MAX) dataRun++;
            if (goI) begin
                ph = 2; tWe = 0; tBe = 4'hF; tAddr = pIAddr; tWdata = 0; elapsed = 0;
            end else if (dw && pDBe == 0) begin
                ph = 3;
            end else if (dw) begin
                ph = 1; tWe = pDWe; tBe = pDBe; tAddr = pDAddr; tWdata = pDWdata; elapsed = 0;
            end
        end else if (ph == 1 || ph == 2) begin
            elapsed++;
            if (pAck) begin
                if (ph == 1) begin nd = 1; eDR = tWe ? 32'd0 : pRdata; end
                else begin ni = 1; eIR = pRdata; end
                ph = 0;
            end else if (elapsed == TIMEOUT) begin
                ne = 1;
                if (ph == 1) begin nd = 1; eDR = 0; end
                else begin ni = 1; eIR = 0; end
                ph = 0;
            end
        end else begin
            nd = 1; eDR = 0; ph = 0;
        end
        eD = nd; eI = ni; eE = ne;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecCnt);
        $fatal(1, "watchdog");
    end

    initial begin
        row_t rows[12];
        row_t fresh;
        int   dAt, iAt, ackN, iReadyCnt;
        logic [31:0] dGot, iGot, firstAddr;
        logic seen;

        rows[0]  = mkRow(0, 1, 4'b0011, 32'h100, 32'hABCD,     3, 32'hFFFF_FFFF, 3,   4,   32'h0,         0);
        rows[1]  = mkRow(0, 0, 4'hF,    32'h200, 32'h0,        1, 32'hDEAD_BEEF, 1,   2,   32'hDEAD_BEEF, 0);
        rows[2]  = mkRow(0, 0, 4'h0,    32'h300, 32'h0,        1, 32'h1234,      0,   2,   32'h0,         0);
        rows[3]  = mkRow(1, 0, 4'h0,    32'h400, 32'h0,        2, 32'h1357_9BDF, 2,   3,   32'h1357_9BDF, 0);
        rows[4]  = mkRow(0, 0, 4'b1000, 32'h504, 32'h0,        5, 32'h0F0F_0F0F, 5,   6,   32'h0F0F_0F0F, 0);
        rows[5]  = mkRow(0, 1, 4'hF,    32'h608, 32'h55,       1, 32'hAAAA_5555, 1,   2,   32'h0,         0);
        rows[6]  = mkRow(0, 0, 4'hF,    32'h70C, 32'h0,        2, 32'h77,        2,   3,   32'h77,        0);
        rows[7]  = mkRow(0, 1, 4'h0,    32'h710, 32'h99,       1, 32'h0,         0,   2,   32'h0,         0);
        rows[8]  = mkRow(0, 0, 4'hF,    32'h714, 32'h0,        2, 32'h66,        2,   3,   32'h66,        0);
        rows[9]  = mkRow(0, 0, 4'h3,    32'h800, 32'h0,        0, 32'hBAD,       255, 256, 32'h0,         1);
        rows[10] = mkRow(0, 0, 4'hC,    32'h804, 32'h0,      255, 32'hCAFE,      255, 256, 32'hCAFE,      0);
        rows[11] = mkRow(1, 0, 4'h0,    32'h900, 32'h0,        0, 32'h1,         255, 256, 32'h0,         1);

        // Reset values, asserted from time zero.
        reset = 1'b0;
        clearInputs();
        #1;
        chk("reset i_rdata", 64'(i_rdata), 64'd0);
        chk("reset i_ready", 64'(i_ready), 64'd0);
        chk("reset d_rdata", 64'(d_rdata), 64'd0);
        chk("reset d_ready", 64'(d_ready), 64'd0);
        chk("reset m_req", 64'(m_req), 64'd0);
        chk("reset m_we", 64'(m_we), 64'd0);
        chk("reset m_be", 64'(m_be), 64'd0);
        chk("reset m_addr", 64'(m_addr), 64'd0);
        chk("reset m_wdata", 64'(m_wdata), 64'd0);
        chk("reset err", 64'(err), 64'd0);
        chk("reset stall", 64'(stall), 64'd0);
        chk("reset state", 64'(dbgState), 64'd0);
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk); #1;

        for (int r = 0; r < 12; r++) runRow(rows[r], $sformatf("row%0d", r));

        // Simultaneous data and fetch reads: data is served first.
        d_req = 1; d_we = 0; d_be = 4'hF; d_addr = 32'hA0;
        i_req = 1; i_addr = 32'hB0;
        dAt = 0; iAt = 0; ackN = 0; dGot = '0; iGot = '0; firstAddr = '0;
        for (int e = 1; e <= 20; e++) begin
            @(posedge clk); #1;
            if (d_ready) begin dAt = e; dGot = d_rdata; d_req = 0; end
            if (i_ready) begin iAt = e; iGot = i_rdata; i_req = 0; end
            if (m_req) begin
                if (ackN == 0) firstAddr = m_addr;
                m_ack = 1;
                m_rdata = (ackN == 0) ? 32'h11 : 32'h22;
                ackN++;
            end else begin
                m_ack = 0;
            end
        end
        chk("both first_grant_addr", 64'(firstAddr), 64'hA0);
        chk("both d_ready_at", 64'(dAt), 64'd2);
        chk("both i_ready_at", 64'(iAt), 64'd4);
        chk("both d_rdata", 64'(dGot), 64'h11);
        chk("both i_rdata", 64'(iGot), 64'h22);
        d_req = 0; i_req = 0; m_ack = 0;

        // Reset in the middle of a fetch grant.
        i_req = 1; i_addr = 32'h800; seen = 0;
        for (int e = 0; e < 10 && !seen; e++) begin
            @(posedge clk); #1;
            seen = m_req;
        end
        chk("rstmid grant_seen", 64'(seen), 64'd1);
        repeat (3) begin @(posedge clk); #1; end
        #1;
        reset = 1'b0; i_req = 0;
        #1;
        chk("rstmid m_req", 64'(m_req), 64'd0);
        chk("rstmid m_addr", 64'(m_addr), 64'd0);
        chk("rstmid m_be", 64'(m_be), 64'd0);
        chk("rstmid i_rdata", 64'(i_rdata), 64'd0);
        chk("rstmid flags", 64'({i_ready, d_ready, err, stall}), 64'd0);
        chk("rstmid state", 64'(dbgState), 64'd0);
        @(posedge clk); @(posedge clk);
        #3 reset = 1'b1;
        iReadyCnt = 0;
        for (int e = 0; e < 5; e++) begin
            @(posedge clk); #1;
            if (i_ready || err) iReadyCnt++;
        end
        chk("rstmid no_pulse", 64'(iReadyCnt), 64'd0);
        fresh = mkRow(1, 0, 4'h0, 32'hA00, 32'h0, 1, 32'h2468, 1, 2, 32'h2468, 0);
        runRow(fresh, "rstmid fresh_fetch");

        // Random traffic against the model.
        doReset();
        ph = 0; elapsed = 0; dataRun = 0;
        tWe = 0; tBe = '0; tAddr = '0; tWdata = '0;
        eD = 0; eI = 0; eE = 0; eDR = '0; eIR = '0;
        pDReq = 0; pDWe = 0; pIReq = 0; pAck = 0; pDBe = '0;
        pDAddr = '0; pDWdata = '0; pIAddr = '0; pRdata = '0;
        dPend = 0; iPend = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            modelEdge();
            chk($sformatf("rnd%0d status", c), 64'({m_req, d_ready, i_ready, err, dbgState}),
                64'({(ph == 1 || ph == 2), eD, eI, eE, 2'(ph)}));
            chk($sformatf("rnd%0d rdata", c), {d_rdata, i_rdata}, {eDR, eIR});
            if (ph == 1 || ph == 2) begin
                chk($sformatf("rnd%0d m_addr", c), 64'(m_addr), 64'(tAddr));
                chk($sformatf("rnd%0d m_ctl", c), 64'({m_we, m_be, m_wdata}), 64'({tWe, tBe, tWdata}));
            end
            if (dPend && eD) dPend = 0;
            if (!dPend && $urandom_range(0, 2) == 0) begin
                dPend = 1;
                d_we = 1'($urandom_range(0, 1));
                d_be = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                d_addr = $urandom;
                d_wdata = $urandom;
            end
            d_req = dPend;
            if (iPend && eI) iPend = 0;
            if (!iPend && $urandom_range(0, 2) == 0) begin
                iPend = 1;
                i_addr = $urandom;
            end
            i_req = iPend;
            if (ph == 1 || ph == 2) m_ack = ($urandom_range(0, 3) == 0);
            else m_ack = ($urandom_range(0, 4) == 0);
            m_rdata = $urandom;
            pDReq = d_req; pDWe = d_we; pDBe = d_be; pDAddr = d_addr; pDWdata = d_wdata;
            pIReq = i_req; pIAddr = i_addr; pAck = m_ack; pRdata = m_rdata;
            #1;
            chk($sformatf("rnd%0d stall", c), 64'(stall), 64'((d_req && !eD) || (i_req && !eI)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
        $finish;
    end

endmodule
